// File: rtl/store_wdata_master.sv
// Store request to single AXI4-Lite write: lane packing, byte strobes, region checks,
// and a one-cycle completion/error pulse back to the pipeline.
module store_wdata_master (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_func3,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        skip_ref
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_DATA = 3'd1,
    S_RESP      = 3'd2,
    S_ERR       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        uart_q, uart_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // Request decode and packing, evaluated on the incoming request so the
  // results can be latched on the accept edge.
  logic        is_uart, is_flash, is_mrom, no_shift;
  logic        misaligned, illegal_f3, req_bad;
  logic [31:0] pack_data;
  logic [3:0]  pack_strb;
  logic [1:0]  lane;

  assign lane     = req_addr[1:0];
  assign is_uart  = (req_addr >= 32'h1000_0000) && (req_addr <= 32'h1000_0006);
  assign is_flash = (req_addr[31:28] == 4'h3);
  assign is_mrom  = (req_addr[31:12] == 20'h2_0000);
  assign no_shift = is_uart | is_flash;

  always_comb begin
    pack_data  = req_data;
    pack_strb  = 4'b1111;
    illegal_f3 = 1'b0;
    misaligned = 1'b0;
    case (req_func3)
      F3_SB: begin
        if (no_shift) begin
          pack_data = {24'b0, req_data[7:0]};
          pack_strb = 4'b0001;
        end else begin
          pack_data = {4{req_data[7:0]}};
          pack_strb = 4'b0001 << lane;
        end
      end
      F3_SH: begin
        if (no_shift) begin
          pack_data = {16'b0, req_data[15:0]};
          pack_strb = 4'b0011;
        end else begin
          pack_data  = {2{req_data[15:0]}};
          pack_strb  = lane[1] ? 4'b1100 : 4'b0011;
          misaligned = lane[0];
        end
      end
      F3_SW: begin
        misaligned = !no_shift && (lane != 2'b00);
      end
      default: illegal_f3 = 1'b1;
    endcase
  end

  assign req_bad = illegal_f3 | is_mrom | misaligned;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    uart_d    = uart_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = pack_data;
          wstrb_d   = pack_strb;
          uart_d    = is_uart;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_bad ? S_ERR : S_ADDR_DATA;
        end
      end
      S_ADDR_DATA: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          err_d   = (bresp != 2'b00);
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'b0;
      wdata_q   <= 32'b0;
      wstrb_q   <= 4'b0;
      uart_q    <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      uart_q    <= uart_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Outputs come only from state and registered flags; no AXI input reaches an AXI output.
  assign req_ready  = (state_q == S_IDLE);
  assign awvalid    = (state_q == S_ADDR_DATA) && !aw_done_q;
  assign wvalid     = (state_q == S_ADDR_DATA) && !w_done_q;
  assign bready     = (state_q == S_RESP);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = (state_q == S_DONE) && err_q;
  assign skip_ref   = (state_q == S_DONE) && uart_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;

endmodule

// File: tb/tb_store_wdata_master.sv
// Directed bench for store_wdata_master: packing, strobes, handshake ordering,
// error paths and asynchronous reset.
module tb_store_wdata_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_func3;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        resp_valid;
  logic        resp_err;
  logic        skip_ref;

  int vectors = 0;
  int miscompares = 0;

  store_wdata_master dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_func3  (req_func3),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bready     (bready),
    .bresp      (bresp),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .skip_ref   (skip_ref)
  );

  always #5 clock = ~clock;

  // Presents a request for one edge; returns 1 time unit after the accept edge (cycle 0).
  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clock);
    req_addr  = a;
    req_data  = d;
    req_func3 = f;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    vectors++;
    if ({req_ready, awvalid, wvalid, bready, resp_valid, resp_err, skip_ref} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 1000000",
               {req_ready, awvalid, wvalid, bready, resp_valid, resp_err, skip_ref});
    end
    $display("reset: req_ready=%b awvalid=%b wvalid=%b", req_ready, awvalid, wvalid);
  endtask

  // Best-case shifted/no-shift store with all readys high; response at cycle 3.
  task automatic test_best_case(input string name, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_wstrb, input logic exp_skip);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    send_req(a, d, f);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL %s_busy: got %b want 0", name, req_ready);
    end
    @(negedge clock);
    vectors++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, a, exp_wdata, exp_wstrb}) begin
      miscompares++;
      $display("FAIL %s_cycle1: got awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b want 1 1 %h %h %b",
               name, awvalid, wvalid, awaddr, wdata, wstrb, a, exp_wdata, exp_wstrb);
    end
    @(negedge clock);
    vectors++;
    if ({awvalid, wvalid, bready, resp_valid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL %s_cycle2: got awv=%b wv=%b bready=%b resp_valid=%b want 0 0 1 0",
               name, awvalid, wvalid, bready, resp_valid);
    end
    @(negedge clock);
    vectors++;
    if ({resp_valid, resp_err, skip_ref, bready} !== {1'b1, 1'b0, exp_skip, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_cycle3: got resp_valid=%b err=%b skip=%b bready=%b want 1 0 %b 0",
               name, resp_valid, resp_err, skip_ref, bready, exp_skip);
    end
    @(negedge clock);
    vectors++;
    if ({req_ready, resp_valid, skip_ref} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_cycle4: got req_ready=%b resp_valid=%b skip=%b want 1 0 0",
               name, req_ready, resp_valid, skip_ref);
    end
    $display("%s: addr=%h wdata=%h wstrb=%b", name, a, exp_wdata, exp_wstrb);
  endtask

  task automatic test_wready_delay;
    awready = 1'b1; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    send_req(32'h8000_0000, 32'hDEAD_BEEF, 3'b010);
    @(negedge clock);
    vectors++;
    if ({awvalid, wvalid} !== 2'b11) begin
      miscompares++; $display("FAIL wdly_cycle1: got awv=%b wv=%b want 1 1", awvalid, wvalid);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      vectors++;
      if ({awvalid, wvalid, bready, wdata, wstrb} !== {3'b010, 32'hDEAD_BEEF, 4'b1111}) begin
        miscompares++;
        $display("FAIL wdly_hold_c%0d: got awv=%b wv=%b bready=%b wdata=%h wstrb=%b want 0 1 0 deadbeef 1111",
                 k, awvalid, wvalid, bready, wdata, wstrb);
      end
      if (k == 4) wready = 1'b1;
    end
    @(negedge clock);
    vectors++;
    if ({wvalid, bready} !== 2'b01) begin
      miscompares++; $display("FAIL wdly_resp: got wv=%b bready=%b want 0 1", wvalid, bready);
    end
    @(negedge clock);
    vectors++;
    if ({resp_valid, resp_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL wdly_done: got resp_valid=%b err=%b want 1 0", resp_valid, resp_err);
    end
    @(negedge clock);
    $display("wready_delay: SW 80000000 completed after W handshake");
  endtask

  task automatic test_error(input string name, input logic [31:0] a, input logic [2:0] f);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    send_req(a, 32'h5555_AAAA, f);
    @(negedge clock);
    vectors++;
    if ({awvalid, wvalid, bready, resp_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s_cycle1: got awv=%b wv=%b bready=%b resp_valid=%b want 0 0 0 0",
               name, awvalid, wvalid, bready, resp_valid);
    end
    @(negedge clock);
    vectors++;
    if ({resp_valid, resp_err, awvalid, wvalid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL %s_cycle2: got resp_valid=%b err=%b awv=%b wv=%b want 1 1 0 0",
               name, resp_valid, resp_err, awvalid, wvalid);
    end
    @(negedge clock);
    vectors++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s_cycle3: got req_ready=%b resp_valid=%b want 1 0", name, req_ready, resp_valid);
    end
    $display("%s: addr=%h func3=%b rejected", name, a, f);
  endtask

  task automatic test_bresp_err;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    send_req(32'h8000_0000, 32'h0BAD_F00D, 3'b010);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if ({resp_valid, resp_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL bresp_err: got resp_valid=%b err=%b want 1 1", resp_valid, resp_err);
    end
    @(negedge clock);
    bresp = 2'b00;
    $display("bresp_err: SW with SLVERR reported");
  endtask

  task automatic test_async_reset;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    send_req(32'h8000_0000, 32'h1111_2222, 3'b010);
    @(negedge clock);
    vectors++;
    if ({awvalid, wvalid} !== 2'b11) begin
      miscompares++; $display("FAIL arst_pre: got awv=%b wv=%b want 1 1", awvalid, wvalid);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({awvalid, wvalid, req_ready, bready} !== 4'b0010) begin
      miscompares++;
      $display("FAIL arst_now: got awv=%b wv=%b req_ready=%b bready=%b want 0 0 1 0",
               awvalid, wvalid, req_ready, bready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if ({req_ready, awvalid, wvalid} !== 3'b100) begin
      miscompares++;
      $display("FAIL arst_after: got req_ready=%b awv=%b wv=%b want 1 0 0", req_ready, awvalid, wvalid);
    end
    $display("async_reset: in-flight store abandoned");
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_func3 = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(posedge clock);
    test_reset();
    #1 reset_n = 1'b1;
    test_best_case("sb_shift", 32'h8000_0003, 32'h1234_56AB, 3'b000, 32'hABAB_ABAB, 4'b1000, 1'b0);
    test_best_case("sb_uart",  32'h1000_0005, 32'h0000_0041, 3'b000, 32'h0000_0041, 4'b0001, 1'b1);
    test_best_case("sh_shift", 32'h8000_0002, 32'hCAFE_BEEF, 3'b001, 32'hBEEF_BEEF, 4'b1100, 1'b0);
    test_best_case("sh_flash", 32'h3000_0003, 32'hCAFE_BEEF, 3'b001, 32'h0000_BEEF, 4'b0011, 1'b0);
    test_wready_delay();
    test_error("sh_misalign", 32'h8000_0001, 3'b001);
    test_error("sw_mrom",     32'h2000_0010, 3'b010);
    test_error("illegal_f3",  32'h8000_0000, 3'b011);
    test_bresp_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_wdata_master.md
# store_wdata_master

Store-side counterpart of the load-data path in the NPC LSU. Accepts one store request (address, rs2 data, func3), forms lane-aligned write data and byte strobes, and drives a single AXI4-Lite write transaction (AW/W/B). It then returns a one-cycle completion or error pulse to the pipeline. Device regions that take data unshifted in the low byte lanes get low-lane packing; the read-only MROM region is rejected without a bus access.

## Interface
- No parameters; data and address widths are fixed at 32.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block idle; a request is accepted on req_valid && req_ready.
- req_addr  in  32  byte address.
- req_data  in  32  rs2 value; the store uses its low 8/16/32 bits.
- req_func3  in  3  000 SB, 001 SH, 010 SW; all other codes are illegal.
- awvalid / awready  out / in  1  AXI write-address handshake.
- awaddr  out  32  equals the latched req_addr, unmodified.
- wvalid / wready  out / in  1  AXI write-data handshake.
- wdata  out  32  lane-placed store data.
- wstrb  out  4  byte strobes.
- bvalid  in  1  write response valid.
- bready  out  1  response accept.
- bresp  in  2  00 OKAY; any other value is an error.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid only with resp_valid; 1 = bus error, misalignment, illegal func3 or MROM write.
- skip_ref  out  1  pulses together with resp_valid when the store targeted UART.

## Operation
- Region decode on the latched address:
  - UART = 0x1000_0000..0x1000_0006.
  - FLASH = 0x3000_0000..0x3FFF_FFFF.
  - MROM = 0x2000_0000..0x2000_0FFF.
  - no_shift = UART | FLASH.
- Shifted packing (normal regions), with a = addr[1:0]:
  - SB: wdata = {4{b}}, wstrb = 1<<a.
  - SH: wdata = {2{h}}, wstrb = a[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data, wstrb = 4'b1111.
- no_shift packing:
  - SB: wdata = {24'b0,b}, wstrb = 4'b0001.
  - SH: wdata = {16'b0,h}, wstrb = 4'b0011.
  - SW: wdata = data, wstrb = 4'b1111.
- Misalignment applies only outside no_shift regions: SH with addr[0]=1, or SW with addr[1:0]≠0. It is an error.
- Error path (misaligned, illegal func3, or MROM): no AW/W/B activity; resp_err=1.
- State machine:
  - IDLE: req_ready=1. On accept, latch the request; go to ERR if the request is erroneous, else to ADDR_DATA.
  - ADDR_DATA: awvalid and wvalid are both asserted on entry. Each channel drops independently after its own handshake, and both may complete in the same cycle or in either order. When both are done, go to RESP.
  - RESP: bready=1. On bvalid, go to DONE and latch err = (bresp≠0).
  - ERR: go to DONE with err=1.
  - DONE: resp_valid=1, resp_err=err, skip_ref=UART hit. Next state is IDLE.
- awaddr, wdata and wstrb are held stable while their valid is high; they are don't-care otherwise.
- bvalid outside RESP is ignored (bready=0).

## Timing
- Reset values: req_ready=1 (IDLE); awvalid, wvalid, bready, resp_valid, resp_err and skip_ref all 0.
- reset_n low at any point (mid-transaction included) returns to IDLE immediately and asynchronously; valids drop without completing the handshake.
- Best-case successful store: accept at cycle 0; AW/W valid at cycle 1 with both readys high; RESP at cycle 2 with bvalid high; resp_valid at cycle 3. req_ready returns at cycle 4.
- Error store: accept at cycle 0, ERR at cycle 1, resp_valid at cycle 2, IDLE at cycle 3.
- At most one outstanding transaction; req_ready=0 from the accept edge until the DONE→IDLE edge.
- All outputs are registered or decoded from state only; there is no combinational path from AXI inputs to AXI outputs.

## Test plan
- SB to 0x8000_0003, data 0x1234_56AB, all readys held high → wdata=0xABAB_ABAB, wstrb=4'b1000, awaddr=0x8000_0003; resp_valid at cycle 3 with resp_err=0 and skip_ref=0.
- SB to UART 0x1000_0005, data 0x41 → wdata=0x0000_0041, wstrb=4'b0001; resp_valid and skip_ref pulse in the same cycle.
- SW to 0x8000_0000 with wready delayed 3 cycles after awready → awvalid drops after 1 cycle; wvalid stays high with stable data until the handshake; RESP is entered only after the W handshake.
- SH to 0x8000_0001, and SW to 0x2000_0010 → no awvalid/wvalid; resp_valid at cycle 2 with resp_err=1.
- SW to 0x8000_0000 with bresp=2'b10 → resp_err=1. Then reset_n pulsed low during ADDR_DATA of a following store → awvalid=wvalid=0 immediately and req_ready=1.
